// File: rtl/omem_readout_streamer_pkg.sv
// Shared widths, FSM encoding and mask helper for the OMEM readout streamer.
package omem_readout_streamer_pkg;

    localparam int unsigned WB_WIDTH  = 32;
    localparam int unsigned MAX_CORES = 8;
    localparam int unsigned CORE_BITS = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } omrs_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [CORE_BITS-1:0] lowest_set(input logic [MAX_CORES-1:0] mask);
        lowest_set = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set = CORE_BITS'(i);
            end
        end
    endfunction

endpackage

// File: rtl/omem_readout_streamer_rd_fifo.sv
// Synchronous FIFO holding {last, tag, data} entries; head is visible without a pop.
module omem_rd_fifo
    import omem_readout_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = WB_WIDTH + CORE_BITS + 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Push onto a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

    // Storage array write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/omem_readout_streamer.sv
// Sweeps enabled OMEM banks, absorbs the read latency and streams tagged words out.
module omem_readout_streamer
    import omem_readout_streamer_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 START_I,
    input  logic [WB_WIDTH-1:0]  WORDS_I,
    input  logic [WB_WIDTH-1:0]  BASE_I,
    input  logic [MAX_CORES-1:0] CORE_MASK_I,
    output logic [CORE_BITS-1:0] OMBSEL_O,
    output logic [WB_WIDTH-1:0]  OMADR_O,
    input  logic [WB_WIDTH-1:0]  OMEM_I,
    output logic [WB_WIDTH-1:0]  DAT_O,
    output logic [CORE_BITS-1:0] TAG_O,
    output logic                 LAST_O,
    output logic                 VLD_O,
    input  logic                 RDY_I,
    output logic                 BUSY_O,
    output logic                 DONE_O
);

    localparam int unsigned ENTRY_W = WB_WIDTH + CORE_BITS + 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W   = $clog2(READ_LATENCY + 1);

    omrs_state_e state_q, state_d;

    logic [MAX_CORES-1:0]    mask_q;
    logic [CORE_BITS-1:0]    core_q;
    logic [WB_WIDTH-1:0]     words_q;
    logic [WB_WIDTH-1:0]     base_q;
    logic [WB_WIDTH-1:0]     idx_q;
    logic [WB_WIDTH-1:0]     adr_q;
    logic [INF_W-1:0]        inflight_q;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_last_q;
    logic [CORE_BITS-1:0]    pipe_tag_q [READ_LATENCY];

    logic             start_sweep;
    logic             start_empty;
    logic             issue;
    logic             word_last;
    logic             issue_last;
    logic             push;
    logic             pop;
    logic             head_last;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [31:0]      occupancy;

    assign start_sweep = (state_q == StIdle) && START_I && (WORDS_I != '0) && (CORE_MASK_I != '0);
    assign start_empty = (state_q == StIdle) && START_I && !start_sweep;

    assign pop        = !fifo_empty && RDY_I;
    assign push       = pipe_vld_q[READ_LATENCY-1];
    assign fifo_wdata = {pipe_last_q[READ_LATENCY-1], pipe_tag_q[READ_LATENCY-1], OMEM_I};
    assign head_last  = fifo_rdata[ENTRY_W-1];

    // Credit counts reads in flight plus buffered words; the head leaving this cycle
    // frees its slot immediately so long latencies still sustain one word per cycle.
    assign occupancy  = 32'(inflight_q) + 32'(fifo_count) - 32'(pop);
    assign issue      = (state_q == StIssue) && (occupancy < FIFO_DEPTH);
    assign word_last  = (idx_q == words_q - WB_WIDTH'(1));
    assign issue_last = word_last && (mask_q == '0);

    assign OMBSEL_O = core_q;
    assign OMADR_O  = adr_q;
    assign VLD_O    = !fifo_empty;
    assign DAT_O    = VLD_O ? fifo_rdata[WB_WIDTH-1:0] : '0;
    assign TAG_O    = VLD_O ? fifo_rdata[WB_WIDTH +: CORE_BITS] : '0;
    assign LAST_O   = VLD_O && head_last;
    assign BUSY_O   = (state_q != StIdle);
    assign DONE_O   = (state_q == StDone);

    // Next-state logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_sweep) begin
                    state_d = StIssue;
                end else if (start_empty) begin
                    state_d = StDone;
                end
            end
            StIssue: begin
                if (issue && issue_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The LAST word is the only thing left once it transfers.
                if (pop && head_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read pointer: current core, remaining mask, word index and address.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            mask_q  <= '0;
            core_q  <= '0;
            words_q <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            adr_q   <= '0;
        end else if (start_sweep) begin
            core_q  <= lowest_set(CORE_MASK_I);
            mask_q  <= CORE_MASK_I & (CORE_MASK_I - MAX_CORES'(1));
            words_q <= WORDS_I;
            base_q  <= BASE_I;
            idx_q   <= '0;
            adr_q   <= BASE_I;
        end else if (issue) begin
            if (word_last) begin
                // After the final read the pointer simply holds.
                if (mask_q != '0) begin
                    core_q <= lowest_set(mask_q);
                    mask_q <= mask_q & (mask_q - MAX_CORES'(1));
                    idx_q  <= '0;
                    adr_q  <= base_q;
                end
            end else begin
                idx_q <= idx_q + WB_WIDTH'(1);
                adr_q <= adr_q + WB_WIDTH'(1);
            end
        end
    end

    // Latency pipe: token travels alongside the read and meets OMEM_I at the end.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            pipe_tag_q[0]  <= core_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
                pipe_tag_q[i]  <= pipe_tag_q[i-1];
            end
        end
    end

    // Reads issued but not yet pushed into the FIFO.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            inflight_q <= '0;
        end else if (issue && !push) begin
            inflight_q <= inflight_q + INF_W'(1);
        end else if (!issue && push) begin
            inflight_q <= inflight_q - INF_W'(1);
        end
    end

    omem_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK_I),
        .rst   (RST_I),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_omem_readout_streamer.sv
// Bench: two streamers (read latency 1 and 3) share stimulus; a queue model per DUT.
module tb_omem_readout_streamer;
    import omem_readout_streamer_pkg::*;

    localparam int NDUT  = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  tag;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] words = '0;
    logic [31:0] base = '0;
    logic [7:0]  mask = '0;
    logic        rdy = 1'b0;

    logic [2:0]  ombsel [NDUT];
    logic [31:0] omadr  [NDUT];
    logic [31:0] dat    [NDUT];
    logic [2:0]  tag    [NDUT];
    logic        last   [NDUT];
    logic        vld    [NDUT];
    logic        busy   [NDUT];
    logic        done   [NDUT];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    word_t       exp_q   [NDUT][$];
    logic [31:0] dat_log [NDUT][$];
    logic [2:0]  tag_log [NDUT][$];
    int          n_xfer    [NDUT];
    int          first_cyc [NDUT];
    int          last_cyc  [NDUT];
    int          done_cnt  [NDUT];
    int          done_base [NDUT];
    logic        last_prev [NDUT];

    bit   rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;

    logic [2:0] exp_tags [12] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2,
                                  3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: random 50% or a fixed level, updated just after each edge.
    initial forever begin
        @(posedge clk);
        #2;
        rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    function automatic logic [31:0] mem_word(input logic [2:0] b, input logic [31:0] a);
        return a ^ {b, 29'h0} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [31:0] rd_pipe [LAT];
        logic [31:0] omem_k;

        assign omem_k = rd_pipe[LAT-1];

        // OMEM bank model: data follows the presented address LAT cycles later.
        always @(posedge clk) begin
            rd_pipe[0] <= mem_word(ombsel[k], omadr[k]);
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        omem_readout_streamer #(
            .READ_LATENCY (LAT),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .CLK_I       (clk),
            .RST_I       (rst),
            .START_I     (start),
            .WORDS_I     (words),
            .BASE_I      (base),
            .CORE_MASK_I (mask),
            .OMBSEL_O    (ombsel[k]),
            .OMADR_O     (omadr[k]),
            .OMEM_I      (omem_k),
            .DAT_O       (dat[k]),
            .TAG_O       (tag[k]),
            .LAST_O      (last[k]),
            .VLD_O       (vld[k]),
            .RDY_I       (rdy),
            .BUSY_O      (busy[k]),
            .DONE_O      (done[k])
        );

        // Compare process: every transfer against the model queue, DONE after LAST.
        initial begin
            word_t e;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (last_prev[k]) check($sformatf("done_after_last_d%0d", k), done[k], 1'b1);
                    last_prev[k] = 1'b0;
                    if (done[k]) begin
                        done_cnt[k]++;
                        check($sformatf("queue_empty_at_done_d%0d", k), exp_q[k].size(), 0);
                    end
                    if (vld[k] && rdy) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            $display("FAIL extra_word_d%0d: got tag %0d data %0h, required none",
                                     k, tag[k], dat[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("dat_d%0d_n%0d", k, n_xfer[k]), dat[k], e.dat);
                            check($sformatf("tag_d%0d_n%0d", k, n_xfer[k]), tag[k], e.tag);
                            check($sformatf("last_d%0d_n%0d", k, n_xfer[k]), last[k], e.last);
                            if (n_xfer[k] == 0) first_cyc[k] = cyc;
                            last_cyc[k] = cyc;
                            n_xfer[k]++;
                            dat_log[k].push_back(dat[k]);
                            tag_log[k].push_back(tag[k]);
                            if (e.last) last_prev[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string name);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s_d%0d", name, k),
                  {ombsel[k], omadr[k], dat[k], tag[k], last[k], vld[k], busy[k], done[k]}, '0);
    endtask

    // Build the expected word list from the sweep rules, then pulse START.
    task automatic begin_sweep(input logic [31:0] w, input logic [31:0] b, input logic [7:0] m);
        int total;
        int n;
        word_t e;
        total = $countones(m) * int'(w);
        for (int k = 0; k < NDUT; k++) begin
            n_xfer[k] = 0;
            dat_log[k].delete();
            tag_log[k].delete();
            done_base[k] = done_cnt[k];
            n = 0;
            for (int c = 0; c < 8; c++) begin
                if (m[c]) begin
                    for (int i = 0; i < int'(w); i++) begin
                        e.dat  = mem_word(3'(c), b + 32'(i));
                        e.tag  = 3'(c);
                        e.last = (n == total - 1);
                        exp_q[k].push_back(e);
                        n++;
                    end
                end
            end
        end
        words = w;
        base  = b;
        mask  = m;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 3000;
        while (budget > 0 && !(done_cnt[0] > done_base[0] && done_cnt[1] > done_base[1])) begin
            @(posedge clk);
            budget--;
        end
        tick(1);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s_done_count_d%0d", name, k), done_cnt[k] - done_base[k], 1);
            check($sformatf("%s_words_left_d%0d", name, k), exp_q[k].size(), 0);
            check($sformatf("%s_idle_d%0d", name, k), busy[k], 1'b0);
        end
    endtask

    task automatic zero_sweep(input logic [31:0] w, input logic [7:0] m, input string name);
        for (int k = 0; k < NDUT; k++) done_base[k] = done_cnt[k];
        words = w;
        mask  = m;
        base  = 32'h55;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s_first_d%0d", name, k), {busy[k], done[k], vld[k]}, 3'b110);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s_second_d%0d", name, k), {busy[k], done[k], vld[k]}, 3'b000);
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s_done_count_d%0d", name, k), done_cnt[k] - done_base[k], 1);
    endtask

    initial begin
        int snap [NDUT];
        for (int k = 0; k < NDUT; k++) last_prev[k] = 1'b0;

        tick(3);
        @(negedge clk);
        outs_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // Single core, four words, ready held high.
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        begin_sweep(32'd4, 32'h10, 8'h01);
        wait_done("t1");
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("t1_count_d%0d", k), dat_log[k].size(), 4);
            check($sformatf("t1_first_d%0d", k), dat_log[k][0], 32'hC0DE_0010);
            check($sformatf("t1_fourth_d%0d", k), dat_log[k][3], 32'hC0DE_0013);
        end

        // Sparse mask, ready high: fixed tag order, no bubbles between words.
        begin_sweep(32'd3, 32'h100, 8'hA5);
        wait_done("t2");
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 12; i++)
                check($sformatf("t2_tag_d%0d_%0d", k, i), tag_log[k][i], exp_tags[i]);
            check($sformatf("t2_span_d%0d", k), last_cyc[k] - first_cyc[k], 11);
        end

        // Same sweep with random ready.
        rdy_rand = 1'b1;
        begin_sweep(32'd3, 32'h100, 8'hA5);
        wait_done("t2r");
        for (int k = 0; k < NDUT; k++) check($sformatf("t2r_count_d%0d", k), n_xfer[k], 12);

        // Long back-pressure: buffer and pipe fill, address holds, stray START ignored.
        begin_sweep(32'd20, 32'h2000, 8'h11);
        tick(6);
        rdy_rand = 1'b0;
        rdy_fixed = 1'b0;
        tick(8);
        words = 32'd1;
        base  = 32'h0;
        mask  = 8'hFF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(11);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("t3_stall_adr_d%0d", k), omadr[k], 32'h2000 + 32'(n_xfer[k] + DEPTH));
            check($sformatf("t3_stall_sel_d%0d", k), ombsel[k], 3'd0);
            check($sformatf("t3_stall_vld_d%0d", k), vld[k], 1'b1);
        end
        rdy_rand = 1'b1;
        wait_done("t3");
        for (int k = 0; k < NDUT; k++) check($sformatf("t3_count_d%0d", k), n_xfer[k], 40);

        // Empty sweeps.
        zero_sweep(32'd0, 8'hFF, "t4_words0");
        zero_sweep(32'd5, 8'h00, "t4_mask0");

        // Address wrap at the top of the range.
        begin_sweep(32'd4, 32'hFFFF_FFFE, 8'h01);
        wait_done("t5");
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("t5_w0_d%0d", k), dat_log[k][0], 32'h3F21_FFFE);
            check($sformatf("t5_w1_d%0d", k), dat_log[k][1], 32'h3F21_FFFF);
            check($sformatf("t5_w2_d%0d", k), dat_log[k][2], 32'hC0DE_0000);
            check($sformatf("t5_w3_d%0d", k), dat_log[k][3], 32'hC0DE_0001);
        end

        // Abort mid-sweep, then a clean second sweep.
        begin_sweep(32'd10, 32'h300, 8'h0F);
        tick(8);
        #1;
        rst = 1'b1;
        #1;
        outs_zero("t6_abort");
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            last_prev[k] = 1'b0;
            snap[k] = done_cnt[k];
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("t6_no_done_d%0d", k), done_cnt[k] - snap[k], 0);
        begin_sweep(32'd5, 32'h40, 8'h42);
        wait_done("t6_second");
        for (int k = 0; k < NDUT; k++) check($sformatf("t6_count_d%0d", k), n_xfer[k], 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
